vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Drives the DrawX/DrawY/blank scan interface that sprite and ROM-based colour blocks consume. Emits hs/vs to the DAC/connector, delayed so that they line up with the one-cycle registered colour those blocks produce. Also provides frame/line strobes and a frame counter for animation logic.

---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster scan bundle: counters, blanking, delayed syncs and strobes shared
// between the timing generator and the colour/animation blocks it feeds.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    // Outputs are presented every pixel clock; there is no valid/ready
    // handshake, a consumer simply samples the bundle on each vga_clk edge.
    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, blanking decode and
// sync outputs delayed to line up with a registered colour pipeline.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned PIPE_DLY  = 1
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master scan
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
        end
        if (PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be in 0..4");
        end
    endgenerate

    // Thresholds are 11 bits wide so a 1024-count total cannot overflow them.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [7:0] frame_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_raw;
    logic       vs_raw;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt     <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hs_raw = (({1'b0, h_cnt} >= HS_START) && ({1'b0, h_cnt} < HS_END))
                    ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = (({1'b0, v_cnt} >= VS_START) && ({1'b0, v_cnt} < VS_END))
                    ? SYNC_POL : ~SYNC_POL;

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign scan.hs = hs_raw;
            assign scan.vs = vs_raw;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe;
            logic [PIPE_DLY-1:0] vs_pipe;

            // Reset flushes every stage so no pre-reset sync pulse leaks out.
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe <= {PIPE_DLY{~SYNC_POL}};
                    vs_pipe <= {PIPE_DLY{~SYNC_POL}};
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < int'(PIPE_DLY); i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign scan.hs = hs_pipe[PIPE_DLY-1];
            assign scan.vs = vs_pipe[PIPE_DLY-1];
        end
    endgenerate

    assign scan.DrawX       = h_cnt;
    assign scan.DrawY       = v_cnt;
    assign scan.blank       = ({1'b0, h_cnt} < H_VIS) && ({1'b0, v_cnt} < V_VIS);
    assign scan.line_start  = (h_cnt == 10'd0);
    assign scan.frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign scan.frame_count = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instances for line timing, a tiny raster
// for frame-level behaviour, mid-frame reset and frame_count wrap.
module tb_vga_timing_gen;
  logic vga_clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int unsigned cyc = 0;

  always #20 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  // a: default 640x480, PIPE_DLY=1, active-low syncs
  vga_timing_gen dut_a (.vga_clk(vga_clk), .reset(rst_a), .scan(if_a));

  // b: 16x12 raster (8/2/3/3, 6/2/2/2), PIPE_DLY=2, active-low
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b0), .PIPE_DLY(2)
  ) dut_b (.vga_clk(vga_clk), .reset(rst_b), .scan(if_b));

  // c: default geometry, no sync delay, active-high
  vga_timing_gen #(.SYNC_POL(1'b1), .PIPE_DLY(0))
    dut_c (.vga_clk(vga_clk), .reset(rst_a), .scan(if_c));

  // signal ids
  localparam int S_X = 0, S_Y = 1, S_BL = 2, S_HS = 3, S_VS = 4;
  localparam int S_LS = 5, S_FS = 6, S_FC = 7, S_ACT = 8, S_FSN = 9;

  typedef struct {
    int unsigned cyc;
    int          dut;
    int          sig;
    logic [9:0]  exp;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // sync-active cycle counters: a/c from release, b from its mid-frame reset
  int unsigned hs_act_a = 0;
  int unsigned hs_act_c = 0;
  int unsigned vs_act_b = 0;
  int unsigned fs_b = 0;

  task automatic expect_at(input int unsigned c, input int d, input int s,
                           input logic [9:0] v);
    exp_t e;
    int pos;
    e.cyc = c; e.dut = d; e.sig = s; e.exp = v;
    pos = exp_q.size();
    while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
    exp_q.insert(pos, e);
  endtask

  function automatic string sig_name(input int s);
    case (s)
      S_X:   return "DrawX";
      S_Y:   return "DrawY";
      S_BL:  return "blank";
      S_HS:  return "hs";
      S_VS:  return "vs";
      S_LS:  return "line_start";
      S_FS:  return "frame_start";
      S_FC:  return "frame_count";
      S_ACT: return "sync_active_cycles";
      default: return "frame_start_pulses";
    endcase
  endfunction

  function automatic logic [9:0] get_val(input int d, input int s);
    logic [9:0] dx, dy;
    logic bl, h, v, ls, fs;
    logic [7:0] fc;
    int unsigned act;
    case (d)
      0: begin
        dx = if_a.DrawX; dy = if_a.DrawY; bl = if_a.blank; h = if_a.hs; v = if_a.vs;
        ls = if_a.line_start; fs = if_a.frame_start; fc = if_a.frame_count; act = hs_act_a;
      end
      1: begin
        dx = if_b.DrawX; dy = if_b.DrawY; bl = if_b.blank; h = if_b.hs; v = if_b.vs;
        ls = if_b.line_start; fs = if_b.frame_start; fc = if_b.frame_count; act = vs_act_b;
      end
      default: begin
        dx = if_c.DrawX; dy = if_c.DrawY; bl = if_c.blank; h = if_c.hs; v = if_c.vs;
        ls = if_c.line_start; fs = if_c.frame_start; fc = if_c.frame_count; act = hs_act_c;
      end
    endcase
    case (s)
      S_X:   return dx;
      S_Y:   return dy;
      S_BL:  return {9'd0, bl};
      S_HS:  return {9'd0, h};
      S_VS:  return {9'd0, v};
      S_LS:  return {9'd0, ls};
      S_FS:  return {9'd0, fs};
      S_FC:  return {2'd0, fc};
      S_ACT: return 10'(act);
      default: return 10'(fs_b);
    endcase
  endfunction

  // monitor: samples on the falling edge, pops every expectation that is due
  always @(negedge vga_clk) begin
    exp_t e;
    logic [9:0] act;
    if (cyc >= 3) begin
      if (if_a.hs === 1'b0) hs_act_a++;
      if (if_c.hs === 1'b1) hs_act_c++;
    end
    if (cyc >= 162) begin
      if (if_b.vs === 1'b0) vs_act_b++;
      if (if_b.frame_start === 1'b1) fs_b++;
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      act = get_val(e.dut, e.sig);
      n_checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d (sampled %0d): got %0d, expected %0d",
                 sig_name(e.sig), e.dut, e.cyc, cyc, act, e.exp);
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;

    // reset held: first edge already gives the reset view
    expect_at(1, 0, S_X, 0);  expect_at(1, 0, S_Y, 0);  expect_at(1, 0, S_BL, 1);
    expect_at(1, 0, S_HS, 1); expect_at(1, 0, S_VS, 1); expect_at(1, 0, S_LS, 1);
    expect_at(1, 0, S_FS, 1); expect_at(1, 0, S_FC, 0);
    expect_at(1, 2, S_HS, 0); expect_at(1, 2, S_VS, 0);
    expect_at(1, 1, S_X, 0);  expect_at(1, 1, S_HS, 1);

    // dut a: h = cyc-3 on line 0
    expect_at(3, 0, S_X, 0);  expect_at(3, 0, S_Y, 0);  expect_at(3, 0, S_BL, 1);
    expect_at(3, 0, S_HS, 1); expect_at(3, 0, S_VS, 1); expect_at(3, 0, S_FC, 0);
    expect_at(4, 0, S_X, 1);  expect_at(4, 0, S_LS, 0); expect_at(4, 0, S_FS, 0);
    expect_at(642, 0, S_BL, 1);
    expect_at(643, 0, S_BL, 0); expect_at(643, 0, S_X, 640);
    expect_at(659, 0, S_X, 656); expect_at(659, 0, S_HS, 1);
    expect_at(660, 0, S_HS, 0);
    expect_at(755, 0, S_HS, 0);
    expect_at(756, 0, S_HS, 1); expect_at(756, 0, S_X, 753);
    expect_at(802, 0, S_X, 799); expect_at(802, 0, S_Y, 0);
    expect_at(802, 0, S_BL, 0);  expect_at(802, 0, S_ACT, 96);
    expect_at(803, 0, S_X, 0);   expect_at(803, 0, S_Y, 1);  expect_at(803, 0, S_LS, 1);
    expect_at(803, 0, S_FS, 0);  expect_at(803, 0, S_BL, 1); expect_at(803, 0, S_VS, 1);
    expect_at(1602, 0, S_ACT, 192);

    // dut c: same-cycle active-high hs
    expect_at(658, 2, S_HS, 0); expect_at(659, 2, S_HS, 1);
    expect_at(754, 2, S_HS, 1); expect_at(755, 2, S_HS, 0);
    expect_at(802, 2, S_ACT, 96);

    // dut b: before mid-frame reset, at (12,9),(13,9) with hs and vs low
    expect_at(159, 1, S_X, 12); expect_at(159, 1, S_HS, 0); expect_at(159, 1, S_VS, 0);
    expect_at(160, 1, S_X, 13); expect_at(160, 1, S_Y, 9);
    expect_at(160, 1, S_HS, 0); expect_at(160, 1, S_VS, 0); expect_at(160, 1, S_FC, 0);
    // reset edge at cycle 161, then no glitch
    expect_at(161, 1, S_X, 0);  expect_at(161, 1, S_Y, 0);  expect_at(161, 1, S_FC, 0);
    expect_at(161, 1, S_FS, 1);
    for (int k = 161; k <= 171; k++) begin
      expect_at(k, 1, S_HS, 1);
      expect_at(k, 1, S_VS, 1);
    end
    expect_at(162, 1, S_X, 1);
    expect_at(173, 1, S_HS, 0); expect_at(175, 1, S_HS, 0); expect_at(176, 1, S_HS, 1);
    expect_at(290, 1, S_VS, 1); expect_at(291, 1, S_VS, 0);
    expect_at(322, 1, S_VS, 0); expect_at(323, 1, S_VS, 1);
    // end-of-frame corner
    expect_at(352, 1, S_X, 15); expect_at(352, 1, S_Y, 11); expect_at(352, 1, S_FC, 0);
    expect_at(352, 1, S_FS, 0); expect_at(352, 1, S_ACT, 32);
    expect_at(353, 1, S_X, 0);  expect_at(353, 1, S_Y, 0);  expect_at(353, 1, S_FC, 1);
    expect_at(353, 1, S_FS, 1); expect_at(353, 1, S_FSN, 1);
    // frame_count progression and 255 -> 0 wrap
    expect_at(24737, 1, S_FC, 128);
    expect_at(49121, 1, S_FC, 255); expect_at(49121, 1, S_FS, 1);
    expect_at(49312, 1, S_FC, 255); expect_at(49312, 1, S_X, 15); expect_at(49312, 1, S_Y, 11);
    expect_at(49313, 1, S_FC, 0);   expect_at(49313, 1, S_FS, 1); expect_at(49313, 1, S_FSN, 256);

    // release both resets after three reset edges
    while (cyc < 3) @(negedge vga_clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    while (cyc < 160) @(negedge vga_clk);
    rst_b = 1'b1;
    while (cyc < 161) @(negedge vga_clk);
    rst_b = 1'b0;

    while (exp_q.size() > 0 && cyc < 49400) @(negedge vga_clk);
    @(negedge vga_clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d expectations left unchecked at cycle %0d, required 0",
               exp_q.size(), cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
